// File: rtl/ring_osc_trim_ctrl_pkg.sv
// Shared constants, FSM encoding and the trim-word decode for the ring oscillator
// frequency-lock controller.
package ring_osc_trim_ctrl_pkg;

  localparam int TRIM_W   = 26;
  localparam int N_STAGES = 13;
  localparam int TVAL_MAX = 26;
  localparam int TVAL_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WARM1 = 3'd1,
    ST_WARM2 = 3'd2,
    ST_WARM3 = 3'd3,
    ST_TRACK = 3'd4
  } state_e;

  // Primary bank (bits 0..12) fills completely before the secondary bank starts
  function automatic logic [TRIM_W-1:0] trim_decode(input logic [TVAL_W-1:0] tval);
    logic [TRIM_W-1:0] word;
    word = {TRIM_W{1'b0}};
    for (int i = 0; i < N_STAGES; i++) begin
      word[i]            = (int'(tval) > i);
      word[N_STAGES + i] = (int'(tval) > (N_STAGES + i));
    end
    return word;
  endfunction

endpackage

// File: rtl/ring_osc_trim_ctrl_if.sv
// Control/status bundle between the trim controller (slave) and its host (master).
interface ring_osc_trim_ctrl_if import ring_osc_trim_ctrl_pkg::*; #(
  parameter int DIV_W = 5
);

  logic              enable;
  logic              dco;
  logic [DIV_W-1:0]  div;
  logic [TRIM_W-1:0] ext_trim;
  logic [TRIM_W-1:0] trim;
  logic              locked;

  modport master (output enable, dco, div, ext_trim, input  trim, locked);
  modport slave  (input  enable, dco, div, ext_trim, output trim, locked);

endinterface

// File: rtl/ring_osc_trim_decode.sv
// Trim level (0..26) to 26-bit oscillator trim word; purely combinational.
module ring_osc_trim_decode import ring_osc_trim_ctrl_pkg::*; (
  input  logic [TVAL_W-1:0] tval,
  output logic [TRIM_W-1:0] trim
);

  assign trim = trim_decode(tval);

endmodule

// File: rtl/ring_osc_trim_ctrl.sv
// Frequency-lock loop for the 13-stage ring oscillator: counts oscillator cycles per
// reference period and steps the trim level until the 2-period sum matches 2*div.
module ring_osc_trim_ctrl import ring_osc_trim_ctrl_pkg::*; #(
  parameter int DIV_W     = 5,
  parameter int CNT_W     = 7,
  parameter int HYST      = 1,
  parameter int LOCK_CNT  = 4,
  parameter int TVAL_INIT = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                osc,
  ring_osc_trim_ctrl_if.slave bus
);

  localparam int                CMP_W    = CNT_W + 3;
  localparam int                STB_W    = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [TVAL_W-1:0] TVAL_RST = TVAL_W'(TVAL_INIT);
  localparam logic [TVAL_W-1:0] TVAL_TOP = TVAL_W'(TVAL_MAX);
  localparam logic [TVAL_W-1:0] TVAL_ONE = TVAL_W'(1);
  localparam logic [TVAL_W-1:0] TVAL_BOT = TVAL_W'(0);
  localparam logic [STB_W-1:0]  STB_TOP  = STB_W'(LOCK_CNT);
  localparam logic [STB_W-1:0]  STB_ONE  = STB_W'(1);
  localparam logic [STB_W-1:0]  STB_ZERO = STB_W'(0);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [TRIM_W-1:0] TRIM_RST = trim_decode(TVAL_RST);

  state_e             state_r, state_nxt_s;
  logic [2:0]         sync_r;
  logic               ref_rise_s, eval_r, eval_go_s, frozen_s;
  logic [CNT_W-1:0]   cnt_r, cur_r, prev_r;
  logic [TVAL_W-1:0]  tval_r, tval_nxt_s, tval_step_s;
  logic [STB_W-1:0]   stable_r, stable_nxt_s;
  logic               locked_r;
  logic [TRIM_W-1:0]  trim_dec_s, trim_dec_r;
  logic signed [CMP_W-1:0] sum_x_s, t2_x_s, hyst_x_s;

  assign frozen_s   = ~bus.enable | bus.dco;
  assign ref_rise_s = sync_r[1] & ~sync_r[2];
  assign eval_go_s  = eval_r & (state_r == ST_TRACK) & ~frozen_s;

  // Reference synchroniser: two metastability flops and one edge-detect flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], osc};
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: three reference edges of warm-up before tracking
  always_comb begin
    state_nxt_s = state_r;
    if (frozen_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_WARM1;
        ST_WARM1: state_nxt_s = ref_rise_s ? ST_WARM2 : ST_WARM1;
        ST_WARM2: state_nxt_s = ref_rise_s ? ST_WARM3 : ST_WARM2;
        ST_WARM3: state_nxt_s = ref_rise_s ? ST_TRACK : ST_WARM3;
        ST_TRACK: state_nxt_s = ST_TRACK;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Saturating period counter with two-period history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r  <= CNT_ZERO;
      cur_r  <= CNT_ZERO;
      prev_r <= CNT_ZERO;
    end else if (state_r == ST_IDLE) begin
      cnt_r  <= CNT_ZERO;
      cur_r  <= CNT_ZERO;
      prev_r <= CNT_ZERO;
    end else if (ref_rise_s) begin
      prev_r <= cur_r;
      cur_r  <= cnt_r;
      cnt_r  <= CNT_ONE;
    end else if (cnt_r != CNT_SAT) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Evaluation runs the cycle after a tracked reference edge so prev/cur are fresh
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eval_r <= 1'b0;
    end else begin
      eval_r <= ref_rise_s & (state_r == ST_TRACK);
    end
  end

  // Signed compare so t2-HYST cannot wrap when div is zero
  assign sum_x_s  = CMP_W'(prev_r) + CMP_W'(cur_r);
  assign t2_x_s   = CMP_W'({bus.div, 1'b0});
  assign hyst_x_s = CMP_W'(HYST);

  always_comb begin
    tval_step_s = tval_r;
    if (sum_x_s > (t2_x_s + hyst_x_s)) begin
      tval_step_s = (tval_r != TVAL_TOP) ? (tval_r + TVAL_ONE) : tval_r;
    end else if (sum_x_s < (t2_x_s - hyst_x_s)) begin
      tval_step_s = (tval_r != TVAL_BOT) ? (tval_r - TVAL_ONE) : tval_r;
    end else begin
      tval_step_s = tval_r;
    end
  end

  // A clamped step leaves tval unchanged and therefore counts toward lock
  always_comb begin
    tval_nxt_s   = tval_r;
    stable_nxt_s = stable_r;
    if (state_r == ST_IDLE) begin
      stable_nxt_s = STB_ZERO;
    end else if (eval_go_s) begin
      tval_nxt_s = tval_step_s;
      if (tval_step_s != tval_r) begin
        stable_nxt_s = STB_ZERO;
      end else if (stable_r != STB_TOP) begin
        stable_nxt_s = stable_r + STB_ONE;
      end else begin
        stable_nxt_s = stable_r;
      end
    end else begin
      tval_nxt_s   = tval_r;
      stable_nxt_s = stable_r;
    end
  end

  ring_osc_trim_decode u_decode (
    .tval (tval_r),
    .trim (trim_dec_s)
  );

  // Trim level, lock tracking and the registered decoded word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tval_r     <= TVAL_RST;
      stable_r   <= STB_ZERO;
      locked_r   <= 1'b0;
      trim_dec_r <= TRIM_RST;
    end else begin
      tval_r     <= tval_nxt_s;
      stable_r   <= stable_nxt_s;
      locked_r   <= (state_nxt_s == ST_TRACK) && (stable_nxt_s == STB_TOP);
      trim_dec_r <= trim_dec_s;
    end
  end

  assign bus.trim   = bus.dco ? bus.ext_trim : trim_dec_r;
  assign bus.locked = locked_r;

endmodule
